// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared definitions for the fetch/execute controller:
//                sequencer state encodings (3-bit) and default PC geometry.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    // Default program-counter width and reset vector
    localparam int unsigned PC_WIDTH_DEF  = 8;
    localparam int unsigned RESET_PC_DEF  = 0;
    localparam int unsigned RETIRED_WIDTH = 16;

    // Sequencer states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_HALT  = 3'd3,
        ST_FAULT = 3'd4
    } seq_state_e;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/pc_next_sel.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_sel
//  Description : Combinational next-PC selector. Priority is
//                stall (hold) > halt (hold) > jump/branch (target) > +1.
//  Ports       : i_pc            current PC
//                i_stall/i_halt  hold requests
//                i_jump/i_branch redirect requests (either one redirects)
//                i_target        redirect target
//                o_next_pc       selected next PC (wraps mod 2^PC_WIDTH)
//  Revision    : 1.0  initial release
// ============================================================================
module pc_next_sel
    import cpu_pkg::*;
#(
    parameter int unsigned PC_WIDTH = PC_WIDTH_DEF
) (
    input  logic [PC_WIDTH-1:0] i_pc,
    input  logic                i_stall,
    input  logic                i_halt,
    input  logic                i_jump,
    input  logic                i_branch,
    input  logic [PC_WIDTH-1:0] i_target,
    output logic [PC_WIDTH-1:0] o_next_pc
);

    always_comb begin
        o_next_pc = i_pc;
        if (i_stall || i_halt) begin
            o_next_pc = i_pc;
        end else if (i_jump || i_branch) begin
            o_next_pc = i_target;
        end else begin
            o_next_pc = i_pc + PC_WIDTH'(1);
        end
    end

endmodule : pc_next_sel
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Fetch/execute controller owning the program counter.
//                Fetches over a req/ack handshake, presents each instruction
//                for one execute slot, selects the next PC and watchdogs
//                stuck fetches.
//  Ports       : Clk, Clear_n (async, active-low)
//                Run                     start / resume
//                Imem_Req, Imem_Addr     fetch request + address (= PC)
//                Imem_Ack                fetch accepted / instruction valid
//                Instr_Valid             high while executing
//                Stall, Halt, Jump, Branch_Taken, Branch_Target  decoder
//                PC, Halted, Fault, Retired                      status
//  Revision    : 1.0  initial release
// ============================================================================
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned          PC_WIDTH      = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0]  RESET_PC      = PC_WIDTH'(RESET_PC_DEF),
    parameter int unsigned          FETCH_TIMEOUT = 15
) (
    input  logic                     Clk,
    input  logic                     Clear_n,
    input  logic                     Run,
    output logic                     Imem_Req,
    output logic [PC_WIDTH-1:0]      Imem_Addr,
    input  logic                     Imem_Ack,
    output logic                     Instr_Valid,
    input  logic                     Stall,
    input  logic                     Halt,
    input  logic                     Jump,
    input  logic                     Branch_Taken,
    input  logic [PC_WIDTH-1:0]      Branch_Target,
    output logic [PC_WIDTH-1:0]      PC,
    output logic                     Halted,
    output logic                     Fault,
    output logic [RETIRED_WIDTH-1:0] Retired
);

    localparam logic [7:0]               C_TIMEOUT = 8'(FETCH_TIMEOUT);
    localparam logic [RETIRED_WIDTH-1:0] C_RET_MAX = '1;

    seq_state_e                 state_q, state_d;
    logic [PC_WIDTH-1:0]        pc_q, pc_d;
    logic [7:0]                 tmo_q, tmo_d;
    logic [RETIRED_WIDTH-1:0]   retired_q, retired_d;
    logic                       imem_req_q, imem_req_d;
    logic                       instr_valid_q, instr_valid_d;
    logic                       halted_q, halted_d;
    logic                       fault_q, fault_d;

    logic                       w_in_exec;
    logic [PC_WIDTH-1:0]        w_next_pc;

    // Decoder inputs only matter during the execute slot; outside EXEC the
    // selector sees no requests and yields PC+1 (used for resume from HALT).
    assign w_in_exec = (state_q == ST_EXEC);

    pc_next_sel #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_next_sel (
        .i_pc      (pc_q),
        .i_stall   (w_in_exec & Stall),
        .i_halt    (w_in_exec & Halt),
        .i_jump    (w_in_exec & Jump),
        .i_branch  (w_in_exec & Branch_Taken),
        .i_target  (Branch_Target),
        .o_next_pc (w_next_pc)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tmo_d     = tmo_q;
        retired_d = retired_q;

        case (state_q)
            ST_IDLE: begin
                if (Run) begin
                    state_d = ST_FETCH;
                    tmo_d   = 8'd0;
                end
            end
            ST_FETCH: begin
                // Ack beats the watchdog even on the final counted cycle
                if (Imem_Ack) begin
                    state_d = ST_EXEC;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                    if (tmo_d == C_TIMEOUT) begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_EXEC: begin
                if (!Stall) begin
                    pc_d      = w_next_pc;
                    retired_d = (retired_q == C_RET_MAX) ? retired_q
                                                         : retired_q + 1'b1;
                    tmo_d     = 8'd0;
                    state_d   = Halt ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                if (Run) begin
                    pc_d    = w_next_pc;
                    tmo_d   = 8'd0;
                    state_d = ST_FETCH;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered copies of the upcoming state
        imem_req_d    = (state_d == ST_FETCH);
        instr_valid_d = (state_d == ST_EXEC);
        halted_d      = (state_d == ST_HALT);
        fault_d       = fault_q | (state_d == ST_FAULT);
    end

    always_ff @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            tmo_q         <= 8'd0;
            retired_q     <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            tmo_q         <= tmo_d;
            retired_q     <= retired_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
        end
    end

    assign Imem_Req    = imem_req_q;
    assign Imem_Addr   = pc_q;
    assign Instr_Valid = instr_valid_q;
    assign PC          = pc_q;
    assign Halted      = halted_q;
    assign Fault       = fault_q;
    assign Retired     = retired_q;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer: directed scenarios with
//                literal expectations, then randomized stimulus compared every
//                cycle against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int TIMEOUT  = 15;
    localparam int RESET_PC = 0;

    logic        Clk = 1'b0;
    logic        Clear_n = 1'b0;
    logic        Run = 1'b0;
    logic        Imem_Req;
    logic [7:0]  Imem_Addr;
    logic        Imem_Ack = 1'b0;
    logic        Instr_Valid;
    logic        Stall = 1'b0;
    logic        Halt = 1'b0;
    logic        Jump = 1'b0;
    logic        Branch_Taken = 1'b0;
    logic [7:0]  Branch_Target = 8'h00;
    logic [7:0]  PC;
    logic        Halted;
    logic        Fault;
    logic [15:0] Retired;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    pc_sequencer dut (
        .Clk           (Clk),
        .Clear_n       (Clear_n),
        .Run           (Run),
        .Imem_Req      (Imem_Req),
        .Imem_Addr     (Imem_Addr),
        .Imem_Ack      (Imem_Ack),
        .Instr_Valid   (Instr_Valid),
        .Stall         (Stall),
        .Halt          (Halt),
        .Jump          (Jump),
        .Branch_Taken  (Branch_Taken),
        .Branch_Target (Branch_Target),
        .PC            (PC),
        .Halted        (Halted),
        .Fault         (Fault),
        .Retired       (Retired)
    );

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_FETCH, M_EXEC, M_HALT, M_FAULT} mmode_t;
    mmode_t m_mode = M_IDLE;
    int     m_pc   = RESET_PC;
    int     m_wait = 0;
    int     m_ret  = 0;
    bit     m_fault = 1'b0;

    always @(posedge Clk or negedge Clear_n) begin
        if (!Clear_n) begin
            m_mode  <= M_IDLE;
            m_pc    <= RESET_PC;
            m_wait  <= 0;
            m_ret   <= 0;
            m_fault <= 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: if (Run) begin m_mode <= M_FETCH; m_wait <= 0; end
                M_FETCH: begin
                    if (Imem_Ack) m_mode <= M_EXEC;
                    else if (m_wait + 1 >= TIMEOUT) begin
                        m_mode <= M_FAULT; m_fault <= 1'b1;
                    end else m_wait <= m_wait + 1;
                end
                M_EXEC: if (!Stall) begin
                    m_ret <= (m_ret < 65535) ? m_ret + 1 : m_ret;
                    if (Halt) m_mode <= M_HALT;
                    else begin
                        m_pc   <= (Jump || Branch_Taken) ? int'(Branch_Target) : (m_pc + 1) % 256;
                        m_mode <= M_FETCH;
                        m_wait <= 0;
                    end
                end
                M_HALT: if (Run) begin
                    m_pc <= (m_pc + 1) % 256; m_mode <= M_FETCH; m_wait <= 0;
                end
                default: ;
            endcase
        end
    end

    bit cmp_en = 1'b0;
    always @(negedge Clk) begin
        if (cmp_en) begin
            chk("m_req",     Imem_Req,    int'(m_mode == M_FETCH));
            chk("m_valid",   Instr_Valid, int'(m_mode == M_EXEC));
            chk("m_halted",  Halted,      int'(m_mode == M_HALT));
            chk("m_fault",   Fault,       m_fault);
            chk("m_pc",      PC,          m_pc);
            chk("m_addr",    Imem_Addr,   m_pc);
            chk("m_retired", Retired,     m_ret);
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ack_pct;
        step();
        step();
        cmp_en = 1'b1;
        // Reset state
        chk("rst_pc", PC, 0);
        chk("rst_req", Imem_Req, 0);
        chk("rst_valid", Instr_Valid, 0);
        chk("rst_halted", Halted, 0);
        chk("rst_fault", Fault, 0);
        chk("rst_retired", Retired, 0);
        Clear_n = 1'b1;

        // 1: straight-line fetch/execute with immediate acks
        Run = 1'b1; Imem_Ack = 1'b1;
        step(); chk("t1_req", Imem_Req, 1); chk("t1_addr0", Imem_Addr, 0);
        step(); chk("t1_valid", Instr_Valid, 1);
        step(); chk("t1_addr1", Imem_Addr, 1);
        step();
        step(); chk("t1_addr2", Imem_Addr, 2);
        step();
        step(); chk("t1_retired", Retired, 3); chk("t1_model_ret", m_ret, 3);

        // 2: wrap 8'hFF -> 8'h00
        Jump = 1'b1; Branch_Target = 8'hFF;
        step(); step(); chk("t2_pc_ff", PC, 8'hFF);
        Jump = 1'b0;
        step(); step();
        chk("t2_pc_wrap", PC, 0); chk("t2_addr_wrap", Imem_Addr, 0);
        chk("t2_req", Imem_Req, 1); chk("t2_model_pc", m_pc, 0);

        // 3: stalled jump at PC=5
        Jump = 1'b1; Branch_Target = 8'h05;
        step(); step(); chk("t3_pc5", PC, 5);
        Branch_Target = 8'h40; Stall = 1'b1;
        step();
        step(); chk("t3_stall1_pc", PC, 5); chk("t3_stall1_valid", Instr_Valid, 1);
        step(); chk("t3_stall2_pc", PC, 5); chk("t3_stall2_ret", Retired, 6);
        Stall = 1'b0;
        step(); chk("t3_pc40", PC, 8'h40); chk("t3_ret", Retired, 7);
        Jump = 1'b0;

        // 4: halt at PC=9 then resume
        Run = 1'b0; Jump = 1'b1; Branch_Target = 8'h09;
        step(); step();
        Jump = 1'b0; Halt = 1'b1;
        step();
        step(); chk("t4_halted", Halted, 1); chk("t4_pc", PC, 9); chk("t4_req", Imem_Req, 0);
        Halt = 1'b0;
        step(); chk("t4_still_halted", Halted, 1);
        Run = 1'b1;
        step(); chk("t4_pc10", PC, 10); chk("t4_req_resume", Imem_Req, 1);

        // 5: fetch watchdog, then ack on the final counted cycle
        Imem_Ack = 1'b0;
        repeat (14) step();
        chk("t5_req_14", Imem_Req, 1); chk("t5_nofault_14", Fault, 0);
        step(); chk("t5_fault", Fault, 1); chk("t5_req_off", Imem_Req, 0);
        repeat (3) step();
        chk("t5_fault_sticky", Fault, 1); chk("t5_run_ignored", Imem_Req, 0);
        Clear_n = 1'b0; step(); Clear_n = 1'b1;
        step();
        repeat (14) step();
        Imem_Ack = 1'b1;
        step(); chk("t5_ack15_valid", Instr_Valid, 1); chk("t5_ack15_nofault", Fault, 0);

        // 6: asynchronous clear mid-fetch, late ack ignored
        Imem_Ack = 1'b0; Run = 1'b0;
        step(); chk("t6_fetch", Imem_Req, 1);
        #2 Clear_n = 1'b0;
        #1 chk("t6_req_drop", Imem_Req, 0); chk("t6_pc_reset", PC, RESET_PC);
        @(negedge Clk); Clear_n = 1'b1; Imem_Ack = 1'b1;
        step(); step(); step();
        chk("t6_no_exec", Instr_Valid, 0); chk("t6_idle", Imem_Req, 0);

        // Randomized phase
        ack_pct = 100;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                case ($urandom_range(0, 3))
                    0: ack_pct = 5;
                    1: ack_pct = 40;
                    2: ack_pct = 75;
                    default: ack_pct = 100;
                endcase
            end
            Run           = ($urandom_range(0, 99) < 30);
            Imem_Ack      = ($urandom_range(0, 99) < ack_pct);
            Stall         = ($urandom_range(0, 99) < 30);
            Halt          = ($urandom_range(0, 99) < 8);
            Jump          = ($urandom_range(0, 99) < 20);
            Branch_Taken  = ($urandom_range(0, 99) < 20);
            Branch_Target = 8'($urandom);
            if ((m_mode == M_FAULT && $urandom_range(0, 9) == 0) || $urandom_range(0, 499) == 0) begin
                #2 Clear_n = 1'b0;
                #1 Clear_n = 1'b1;
            end
            step();
        end

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pc_sequencer
`default_nettype wire
